// File: rtl/cpu_pkg.sv
// Shared front-end constants and the decode-facing fetch entry layout.
// Default widths and the reset fetch address live here for reuse across the core.
package cpu_pkg;

  localparam int unsigned CPU_ADDR_W = 16;
  localparam int unsigned CPU_DATA_W = 16;
  localparam logic [CPU_ADDR_W-1:0] CPU_RESET_PC = '0;

  typedef struct packed {
    logic [CPU_ADDR_W-1:0] pc;
    logic [CPU_DATA_W-1:0] instr;
  } fetch_entry_t;

endpackage : cpu_pkg

// File: rtl/fetch_buffer.sv
// Two-entry FIFO holding fetched {pc, instr} pairs between the ROM and decode.
// slot0 is always the head; a flush empties it without clearing stale contents.
module fetch_buffer
  import cpu_pkg::*;
#(
  parameter type entry_t = fetch_entry_t
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  entry_t     push_data,
  input  logic       pop,
  input  logic       flush,
  output logic [1:0] count,
  output entry_t     head
);

  entry_t     slot0_q, slot0_d;
  entry_t     slot1_q, slot1_d;
  logic [1:0] count_q, count_d;

  // NOTE: every always_comb output gets a default first, otherwise the
  // unassigned branches infer latches.
  always_comb begin
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    count_d = count_q;
    if (flush) begin
      count_d = 2'd0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) slot0_d = push_data;
          else                 slot1_d = push_data;
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          slot0_d = slot1_q;
          count_d = count_q - 2'd1;
        end
        2'b11: begin
          // Pop and push together: occupancy is unchanged, order is preserved.
          if (count_q == 2'd2) begin
            slot0_d = slot1_q;
            slot1_d = push_data;
          end else begin
            slot0_d = push_data;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: the two data slots are reset too, because out_pc/out_instruct must
  // read zero after reset; a deeper buffer would normally leave data unreset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot0_q <= '0;
      slot1_q <= '0;
      count_q <= 2'd0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign head  = slot0_q;

endmodule : fetch_buffer

// File: rtl/instruction_fetch.sv
// Fetch unit: owns the PC, issues one synchronous ROM read per cycle, tracks the
// read in flight and hands {pc, instr} to decode over a valid/ready handshake.
module instruction_fetch
  import cpu_pkg::*;
#(
  parameter int unsigned            ADDR_WIDTH = CPU_ADDR_W,
  parameter int unsigned            DATA_WIDTH = CPU_DATA_W,
  parameter logic [ADDR_WIDTH-1:0]  RESET_PC   = ADDR_WIDTH'(CPU_RESET_PC)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fetch_en,
  output logic                  mem_read_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_instruct,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_pc,
  output logic [DATA_WIDTH-1:0] out_instruct
);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] instr;
  } entry_t;

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  inflight_q, inflight_d;
  logic [ADDR_WIDTH-1:0] inflight_pc_q, inflight_pc_d;

  logic       issue;
  logic       push;
  logic       pop;
  logic [2:0] occupancy;
  logic [1:0] buf_count;
  entry_t     push_entry;
  entry_t     head;

  always_comb begin
    pop       = out_valid & out_ready & ~redirect_valid;
    // Entries held plus the read returning next cycle, after this cycle's pop.
    occupancy = {1'b0, buf_count} + {2'b00, inflight_q} - {2'b00, pop};
    // Reset gating keeps the ROM idle while rst_n is low.
    issue     = rst_n & fetch_en & (redirect_valid | (occupancy < 3'd2));
    mem_addr  = redirect_valid ? redirect_pc : pc_q;

    pc_d          = redirect_valid ? redirect_pc : pc_q;
    inflight_d    = issue;
    inflight_pc_d = inflight_pc_q;
    if (issue) begin
      pc_d          = mem_addr + ADDR_WIDTH'(1);
      inflight_pc_d = mem_addr;
    end

    // A redirect discards the data returning for the old stream.
    push             = inflight_q & ~redirect_valid;
    push_entry.pc    = inflight_pc_q;
    push_entry.instr = mem_instruct;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  fetch_buffer #(
    .entry_t (entry_t)
  ) u_fetch_buffer (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (redirect_valid),
    .count     (buf_count),
    .head      (head)
  );

  assign mem_read_en  = issue;
  assign out_valid    = (buf_count != 2'd0);
  assign out_pc       = head.pc;
  assign out_instruct = head.instr;

endmodule : instruction_fetch
